// File: rtl/package_settings_V1.sv
// Shared settings for the trapezoidal shaper output stage: sample widths, window length, FSM states.
package package_settings_V1;

  localparam int SIZE_OUT_DATA = 16;
  localparam int SIZE_CNT      = 4;
  localparam int k             = 5;
  localparam int l             = 8;
  localparam int WIN_LEN       = k + l;

  typedef enum logic [1:0] {
    IDLE,
    WINDOW,
    WAIT_LOW
  } state_t;

endpackage

// File: rtl/trapezoid_peak_reader_if.sv
// Sample stream in and event stream out of the peak reader, grouped as one bus.
interface trapezoid_peak_reader_if #(
  parameter int SIZE_OUT_DATA = 16,
  parameter int TS_W          = 32
);

  logic signed [SIZE_OUT_DATA-1:0] in_data;
  logic                            in_valid;
  logic signed [SIZE_OUT_DATA-1:0] out_amp;
  logic        [TS_W-1:0]          out_ts;
  logic                            out_valid;
  logic                            out_ready;

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  out_amp,
    input  out_ts,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output out_amp,
    output out_ts,
    output out_valid
  );

endinterface

// File: rtl/trapezoid_event_outreg.sv
// Event holding register with valid/ready handshake and saturating drop counter.
module trapezoid_event_outreg #(
  parameter int SIZE_OUT_DATA = 16,
  parameter int TS_W          = 32,
  parameter int SIZE_CNT      = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            ev_strobe,
  input  logic signed [SIZE_OUT_DATA-1:0] ev_amp,
  input  logic        [TS_W-1:0]          ev_ts,
  input  logic                            out_ready,
  output logic signed [SIZE_OUT_DATA-1:0] out_amp,
  output logic        [TS_W-1:0]          out_ts,
  output logic                            out_valid,
  output logic        [SIZE_CNT-1:0]      drop_cnt
);

  logic signed [SIZE_OUT_DATA-1:0] amp_q, amp_d;
  logic        [TS_W-1:0]          ts_q, ts_d;
  logic                            valid_q, valid_d;
  logic        [SIZE_CNT-1:0]      drop_q, drop_d;
  logic                            accept;

  always_comb begin
    amp_d   = amp_q;
    ts_d    = ts_q;
    valid_d = valid_q;
    drop_d  = drop_q;
    // The slot is free if empty or being emptied this cycle.
    accept  = !valid_q || out_ready;
    if (ev_strobe && accept) begin
      amp_d   = ev_amp;
      ts_d    = ev_ts;
      valid_d = 1'b1;
    end else begin
      if (out_ready) begin
        valid_d = 1'b0;
      end
      if (ev_strobe && (drop_q != {SIZE_CNT{1'b1}})) begin
        drop_d = drop_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      amp_q   <= '0;
      ts_q    <= '0;
      valid_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      amp_q   <= amp_d;
      ts_q    <= ts_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign out_amp   = amp_q;
  assign out_ts    = ts_q;
  assign out_valid = valid_q;
  assign drop_cnt  = drop_q;

endmodule

// File: rtl/trapezoid_peak_reader.sv
// Threshold-triggered peak/timestamp capture over a k+l sample window of the shaper output.
// Optional: define PEAK_PILEUP_REJECT_EN to discard events whose last window sample is above threshold.
module trapezoid_peak_reader #(
  parameter int SIZE_OUT_DATA = package_settings_V1::SIZE_OUT_DATA,
  parameter int SIZE_CNT      = package_settings_V1::SIZE_CNT,
  parameter int k             = package_settings_V1::k,
  parameter int l             = package_settings_V1::l,
  parameter int TS_W          = 32,
  parameter logic signed [SIZE_OUT_DATA-1:0] THRESHOLD = 100
) (
  input  logic                   clk,
  input  logic                   reset_n,
  trapezoid_peak_reader_if.slave bus,
  output logic                   busy,
  output logic [SIZE_CNT-1:0]    drop_cnt
);

  import package_settings_V1::*;

  localparam int WinLen = k + l;
  localparam int IdxW   = $clog2(WinLen);

  state_t                          state_q, state_d;
  logic        [IdxW-1:0]          idx_q, idx_d;
  logic signed [SIZE_OUT_DATA-1:0] peak_q, peak_d;
  logic        [TS_W-1:0]          ts_q, ts_d;
  logic        [TS_W-1:0]          cnt_q, cnt_d;

  logic                            above;
  logic signed [SIZE_OUT_DATA-1:0] larger;
  logic                            complete;
  logic                            ev_strobe;
  logic signed [SIZE_OUT_DATA-1:0] amp_w;
  logic        [TS_W-1:0]          ts_w;
  logic                            valid_w;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    peak_d   = peak_q;
    ts_d     = ts_q;
    complete = 1'b0;
    above    = bus.in_data > THRESHOLD;
    larger   = (bus.in_data > peak_q) ? bus.in_data : peak_q;
    cnt_d    = bus.in_valid ? cnt_q + 1'b1 : cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && above) begin
          state_d = WINDOW;
          idx_d   = IdxW'(1);
          peak_d  = bus.in_data;
          ts_d    = cnt_q;
        end
      end
      WINDOW: begin
        if (bus.in_valid) begin
          peak_d = larger;
          if (idx_q == IdxW'(WinLen - 1)) begin
            complete = 1'b1;
            idx_d    = '0;
            state_d  = above ? WAIT_LOW : IDLE;
          end else begin
            idx_d = IdxW'(idx_q + 1'b1);
          end
        end
      end
      WAIT_LOW: begin
        if (bus.in_valid && !above) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PEAK_PILEUP_REJECT_EN
  // A last sample still above threshold means the next pulse is piling up on this one.
  assign ev_strobe = complete && !above;
`else
  assign ev_strobe = complete;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      peak_q  <= '0;
      ts_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      peak_q  <= peak_d;
      ts_q    <= ts_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != IDLE);

  trapezoid_event_outreg #(
    .SIZE_OUT_DATA (SIZE_OUT_DATA),
    .TS_W          (TS_W),
    .SIZE_CNT      (SIZE_CNT)
  ) u_outreg (
    .clk       (clk),
    .reset_n   (reset_n),
    .ev_strobe (ev_strobe),
    .ev_amp    (larger),
    .ev_ts     (ts_q),
    .out_ready (bus.out_ready),
    .out_amp   (amp_w),
    .out_ts    (ts_w),
    .out_valid (valid_w),
    .drop_cnt  (drop_cnt)
  );

  assign bus.out_amp   = amp_w;
  assign bus.out_ts    = ts_w;
  assign bus.out_valid = valid_w;

endmodule

// File: tb/tb_trapezoid_peak_reader.sv
// Directed bench for trapezoid_peak_reader: pulse capture, backpressure, pile-up, reset, gaps.
module tb_trapezoid_peak_reader;

  logic       clk;
  logic       reset_n;
  logic       busy;
  logic [3:0] drop_cnt;

  trapezoid_peak_reader_if #(.SIZE_OUT_DATA(16), .TS_W(32)) bus ();

  trapezoid_peak_reader dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int nvalid   = 0;
  int ev_n     = 0;
  int ev_cyc   = 0;
  int trig_cyc = 0;
  int exp_ts   = 0;
  int e0       = 0;
  logic              rdy;
  logic              last_busy;
  logic              busy_mid;
  logic signed [15:0] ev_amp;
  logic [31:0]       ev_ts;
  logic signed [15:0] pulse [17];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, observe just before the next rising edge.
  task automatic cycle(input logic signed [15:0] d, input logic v);
    @(negedge clk);
    bus.in_data   = d;
    bus.in_valid  = v;
    bus.out_ready = rdy;
    cyc++;
    if (v && reset_n) nvalid++;
    #4;
    if (bus.out_valid && bus.out_ready) begin
      ev_n++;
      ev_amp = bus.out_amp;
      ev_ts  = bus.out_ts;
      ev_cyc = cyc;
    end
    last_busy = busy;
  endtask

  task automatic run_pulse(input logic gaps);
    for (int i = 0; i < 17; i++) begin
      if (i == 3) begin
        exp_ts   = nvalid;
        trig_cyc = cyc + 1;
      end
      cycle(pulse[i], 1'b1);
      if (i == 5) busy_mid = last_busy;
      if (gaps) cycle(16'sd5000, 1'b0);
    end
  endtask

  task automatic short_pulse(input logic signed [15:0] peak);
    cycle(16'sd200, 1'b1);
    cycle(peak, 1'b1);
    for (int i = 0; i < 11; i++) cycle(16'sd0, 1'b1);
    cycle(16'sd0, 1'b1);
    cycle(16'sd0, 1'b1);
  endtask

  initial begin
    pulse = '{16'sd0, 16'sd0, 16'sd50, 16'sd200, 16'sd400, 16'sd600, 16'sd800, 16'sd1000,
              16'sd1000, 16'sd1000, 16'sd800, 16'sd600, 16'sd400, 16'sd200, 16'sd0, 16'sd0,
              16'sd0};
    rdy          = 1'b1;
    reset_n      = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    busy_mid     = 1'b0;

    // Reset state
    cycle(16'sd0, 1'b0);
    cycle(16'sd0, 1'b0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_amp", 32'(bus.out_amp), 0);
    chk("rst_ts", bus.out_ts, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    reset_n = 1'b1;
    nvalid  = 0;

    // Single pulse
    e0 = ev_n;
    run_pulse(1'b0);
    for (int i = 0; i < 3; i++) cycle(16'sd0, 1'b1);
    chk("p1_busy_mid", 32'(busy_mid), 1);
    chk("p1_events", ev_n - e0, 1);
    chk("p1_amp", 32'(ev_amp), 1000);
    chk("p1_ts", ev_ts, 3);
    chk("p1_latency", ev_cyc - trig_cyc, 13);
    chk("p1_busy_end", 32'(last_busy), 0);

    // Backpressure: second event is dropped, first held
    rdy = 1'b0;
    e0  = ev_n;
    cycle(16'sd0, 1'b1);
    exp_ts = nvalid;
    short_pulse(16'sd1000);
    short_pulse(16'sd700);
    chk("bp_valid", 32'(bus.out_valid), 1);
    chk("bp_amp", 32'(bus.out_amp), 1000);
    chk("bp_ts", bus.out_ts, 32'(exp_ts));
    chk("bp_drop", 32'(drop_cnt), 1);
    chk("bp_no_accept", ev_n - e0, 0);
    rdy = 1'b1;
    cycle(16'sd0, 1'b1);
    chk("bp_accept", ev_n - e0, 1);
    chk("bp_accept_amp", 32'(ev_amp), 1000);
    rdy = 1'b0;
    cycle(16'sd0, 1'b1);
    chk("bp_valid_clear", 32'(bus.out_valid), 0);
    rdy = 1'b1;

    // Pile-up: last window sample 500, then 300 (no retrigger), then 50
    e0 = ev_n;
    for (int i = 0; i < 12; i++) cycle(16'sd150, 1'b1);
    cycle(16'sd500, 1'b1);
    cycle(16'sd300, 1'b1);
    chk("pu_busy_waitlow", 32'(last_busy), 1);
    cycle(16'sd50, 1'b1);
    chk("pu_busy_300", 32'(last_busy), 1);
    cycle(16'sd0, 1'b1);
    chk("pu_busy_idle", 32'(last_busy), 0);
    for (int i = 0; i < 14; i++) cycle(16'sd0, 1'b1);
`ifdef PEAK_PILEUP_REJECT_EN
    chk("pu_events", ev_n - e0, 0);
`else
    chk("pu_events", ev_n - e0, 1);
    chk("pu_amp", 32'(ev_amp), 500);
`endif
    chk("pu_drop", 32'(drop_cnt), 1);
    chk("pu_busy_after", 32'(last_busy), 0);

    // Reset mid-window at index 6
    cycle(16'sd0, 1'b1);
    cycle(16'sd200, 1'b1);
    cycle(16'sd400, 1'b1);
    cycle(16'sd600, 1'b1);
    cycle(16'sd800, 1'b1);
    cycle(16'sd1000, 1'b1);
    cycle(16'sd1000, 1'b1);
    reset_n = 1'b0;
    cycle(16'sd1000, 1'b1);
    chk("mr_valid", 32'(bus.out_valid), 0);
    chk("mr_amp", 32'(bus.out_amp), 0);
    chk("mr_ts", bus.out_ts, 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_drop", 32'(drop_cnt), 0);
    cycle(16'sd0, 1'b0);
    reset_n = 1'b1;
    nvalid  = 0;
    e0      = ev_n;
    run_pulse(1'b0);
    for (int i = 0; i < 3; i++) cycle(16'sd0, 1'b1);
    chk("mr_events", ev_n - e0, 1);
    chk("mr_amp_ev", 32'(ev_amp), 1000);
    chk("mr_ts_ev", ev_ts, 3);

    // Negative samples then gapped pulse
    e0 = ev_n;
    for (int i = 0; i < 5; i++) cycle(-16'sd3000, 1'b1);
    chk("neg_no_trig", 32'(last_busy), 0);
    run_pulse(1'b1);
    for (int i = 0; i < 3; i++) cycle(16'sd0, 1'b1);
    chk("gap_events", ev_n - e0, 1);
    chk("gap_amp", 32'(ev_amp), 1000);
    chk("gap_ts", ev_ts, 32'(exp_ts));
    chk("gap_latency", ev_cyc - trig_cyc, 25);
    chk("gap_busy_end", 32'(last_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
